// File: rtl/lcd_bus_capture.sv
// HD44780-style bus snooper: rebuilds bytes, DDRAM address and a 2x14 text image.
// Optional LCD_CAPTURE_ENTRY_MODE_EN enables the entry-mode I/D (decrement) setting.
module lcd_bus_capture #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_4,
  input  logic         lcd_5,
  input  logic         lcd_6,
  input  logic         lcd_7,
  output logic [223:0] text,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         byte_valid,
  output logic         mode4,
  output logic [6:0]   addr
);

  typedef enum logic [1:0] {S_MODE8, S_HI, S_LO} state_t;

  // sync word layout: {e, rs, rw, d7, d6, d5, d4}
  logic [6:0]   r_sync [SYNC_STAGES];
  logic [6:0]   w_s;
  logic         r_e_prev;
  logic         w_fall;
  logic         r_stb;
  logic         r_rs;
  logic [3:0]   r_nib;
  logic [3:0]   r_hi;
  state_t       r_state;
  state_t       w_next;
  logic         w_done;
  logic [7:0]   w_byte;
  logic [223:0] r_text;
  logic [7:0]   r_byte;
  logic         r_byte_rs;
  logic         r_valid;
  logic [6:0]   r_addr;
  logic         w_in_lo;
  logic         w_in_hi;
  logic [4:0]   w_idx;
  logic [6:0]   w_step;
`ifdef LCD_CAPTURE_ENTRY_MODE_EN
  logic         r_id;
`endif

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_fall = r_e_prev & ~w_s[6];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_e_prev <= 1'b0;
      r_stb    <= 1'b0;
      r_rs     <= 1'b0;
      r_nib    <= 4'h0;
    end else begin
      r_sync[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_7, lcd_6, lcd_5, lcd_4};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_e_prev <= w_s[6];
      r_stb    <= w_fall & ~w_s[4];
      r_rs     <= w_s[5];
      r_nib    <= w_s[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_MODE8;
      r_hi    <= 4'h0;
    end else begin
      r_state <= w_next;
      if (r_stb && r_state == S_HI) r_hi <= r_nib;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_MODE8: if (r_stb && r_nib == 4'h2 && !r_rs) w_next = S_HI;
      S_HI:    if (r_stb) w_next = S_LO;
      S_LO:    if (r_stb) w_next = (!r_rs && r_hi == 4'h3) ? S_MODE8 : S_HI;
      default: w_next = S_MODE8;
    endcase
  end

  always_comb begin
    w_done = 1'b0;
    w_byte = {r_nib, 4'h0};
    mode4  = (r_state != S_MODE8);
    unique case (r_state)
      S_MODE8: w_done = r_stb;
      S_LO: begin
        w_done = r_stb;
        w_byte = {r_hi, r_nib};
      end
      default: ;
    endcase
  end

  // line 2 (0x40..0x4D) maps onto chars 14..27
  assign w_in_lo = (r_addr <= 7'h0D);
  assign w_in_hi = (r_addr >= 7'h40) && (r_addr <= 7'h4D);
  assign w_idx   = w_in_lo ? r_addr[4:0] : r_addr[4:0] + 5'd14;
`ifdef LCD_CAPTURE_ENTRY_MODE_EN
  assign w_step  = r_id ? r_addr + 7'd1 : r_addr - 7'd1;
`else
  assign w_step  = r_addr + 7'd1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_text    <= {28{8'h20}};
      r_byte    <= 8'h00;
      r_byte_rs <= 1'b0;
      r_valid   <= 1'b0;
      r_addr    <= 7'h00;
`ifdef LCD_CAPTURE_ENTRY_MODE_EN
      r_id      <= 1'b1;
`endif
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_byte    <= w_byte;
        r_byte_rs <= r_rs;
        if (r_rs) begin
          for (int i = 0; i < 28; i++)
            if ((w_in_lo || w_in_hi) && w_idx == 5'(i))
              r_text[8*(27-i) +: 8] <= w_byte;
          r_addr <= w_step;
        end else begin
          unique case (1'b1)
            w_byte[7]:            r_addr <= w_byte[6:0];
            w_byte == 8'h01: begin
              r_text <= {28{8'h20}};
              r_addr <= 7'h00;
            end
            w_byte[7:1] == 7'h01: r_addr <= 7'h00;
`ifdef LCD_CAPTURE_ENTRY_MODE_EN
            w_byte[7:2] == 6'h01: r_id <= w_byte[1];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign text       = r_text;
  assign byte_out   = r_byte;
  assign byte_rs    = r_byte_rs;
  assign byte_valid = r_valid;
  assign addr       = r_addr;

endmodule

// File: tb/tb_lcd_bus_capture.sv
// Directed + randomized bench for lcd_bus_capture against a strobe-level model.
// Timing of each byte_valid pulse is checked relative to the raw lcd_e fall.
module tb_lcd_bus_capture;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic lcd_4 = 1'b0, lcd_5 = 1'b0, lcd_6 = 1'b0, lcd_7 = 1'b0;
  logic [223:0] text;
  logic [7:0]   byte_out;
  logic         byte_rs, byte_valid, mode4;
  logic [6:0]   addr;

  lcd_bus_capture #(.SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
    .text(text), .byte_out(byte_out), .byte_rs(byte_rs),
    .byte_valid(byte_valid), .mode4(mode4), .addr(addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_ch [28];
  logic [6:0] m_addr;
  bit         m_m4, m_have, m_id;
  logic [3:0] m_hi;
  logic [7:0] m_byte;
  bit         m_rs;

  task automatic chk(input string tag, input logic [223:0] obs, input logic [223:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [223:0] m_text();
    logic [223:0] t;
    for (int i = 0; i < 28; i++) t[8*(27-i) +: 8] = m_ch[i];
    return t;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 28; i++) m_ch[i] = 8'h20;
    m_addr = 0; m_m4 = 0; m_have = 0; m_id = 1; m_hi = 0;
    m_byte = 0; m_rs = 0;
  endtask

  task automatic m_apply(input logic [7:0] b, input bit rs);
    int a;
    a = m_addr;
    if (rs) begin
      if (a <= 13) m_ch[a] = b;
      else if (a >= 64 && a <= 77) m_ch[a - 64 + 14] = b;
      m_addr = m_id ? m_addr + 7'd1 : m_addr - 7'd1;
    end else if (b == 8'h01) begin
      for (int i = 0; i < 28; i++) m_ch[i] = 8'h20;
      m_addr = 0;
    end else if (b == 8'h02 || b == 8'h03) begin
      m_addr = 0;
    end else if (b >= 8'h80) begin
      m_addr = 7'(b - 8'h80);
    end else if (b >= 8'h04 && b <= 8'h07) begin
`ifdef LCD_CAPTURE_ENTRY_MODE_EN
      m_id = b[1];
`endif
    end
  endtask

  task automatic m_strobe(input logic [3:0] nib, input bit rs, input bit rw, output bit done);
    done = 0;
    if (rw) return;
    if (!m_m4) begin
      m_byte = {nib, 4'h0};
      done = 1;
      if (nib == 4'h2 && !rs) m_m4 = 1;
    end else if (!m_have) begin
      m_hi = nib;
      m_have = 1;
    end else begin
      m_byte = {m_hi, nib};
      m_have = 0;
      done = 1;
      if (!rs && m_hi == 4'h3) m_m4 = 0;
    end
    if (done) begin
      m_rs = rs;
      m_apply(m_byte, rs);
    end
  endtask

  task automatic strobe(input logic [3:0] nib, input bit rs, input bit rw);
    bit done;
    logic [7:0] got, exp;
    @(negedge clk);
    lcd_e = 1; lcd_rs = rs; lcd_rw = rw;
    {lcd_7, lcd_6, lcd_5, lcd_4} = nib;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    m_strobe(nib, rs, rw, done);
    lcd_e = 0;
    got = 0; exp = 0;
    for (int j = 1; j <= S + 4; j++) begin
      @(posedge clk); #1;
      got[j] = byte_valid;
    end
    if (done) exp[S+2] = 1'b1;
    chk("pulse_timing", got, exp);
    chk("mode4", mode4, m_m4);
    if (done) begin
      chk("byte_out", byte_out, m_byte);
      chk("byte_rs", byte_rs, m_rs);
      chk("addr", addr, m_addr);
      chk("text", text, m_text());
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs);
    if (m_m4) begin
      strobe(b[7:4], rs, 0);
      strobe(b[3:0], rs, 0);
    end else begin
      strobe(b[7:4], rs, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    lcd_e = 0; lcd_rw = 0;
    reset = 1;
    #1;
    m_reset();
    chk("rst_text", text, {28{8'h20}});
    chk("rst_byte_out", byte_out, 8'h00);
    chk("rst_flags", {byte_rs, byte_valid, mode4}, 3'b000);
    chk("rst_addr", addr, 7'h00);
    repeat (3) @(negedge clk);
    reset = 0;
  endtask

  task automatic init4();
    strobe(4'h3, 0, 0);
    strobe(4'h3, 0, 0);
    strobe(4'h3, 0, 0);
    strobe(4'h2, 0, 0);
  endtask

  initial begin
    logic [7:0] seen;
    logic [7:0] b;
    bit rs;
    m_reset();
    #2;
    do_reset();

    init4();
    chk("init_mode4", mode4, 1'b1);
    chk("init_last", byte_out, 8'h20);

    send_byte(8'h43, 1);
    send_byte(8'h61, 1);
    chk("Ca_text", text[223:208], 16'h4361);
    chk("Ca_addr", addr, 7'h02);

    send_byte(8'hC0, 0);
    send_byte(8'h6D, 1);
    chk("line2_char", text[111:104], 8'h6D);
    chk("line2_addr", addr, 7'h41);

    send_byte(8'hFF, 0);
    send_byte(8'h55, 1);
    chk("wrap_up", addr, 7'h00);

    send_byte(8'h80, 0);
    for (int i = 0; i < 14; i++) send_byte(8'($urandom_range(33, 126)), 1);
    send_byte(8'hC0, 0);
    for (int i = 0; i < 14; i++) send_byte(8'($urandom_range(33, 126)), 1);
    send_byte(8'h01, 0);
    chk("clear_text", text, {28{8'h20}});
    chk("clear_addr", addr, 7'h00);

    @(negedge clk);
    lcd_e = 1; lcd_rw = 0;
    seen = 0;
    for (int j = 0; j < 50; j++) begin
      @(posedge clk); #1;
      seen[0] = seen[0] | byte_valid;
    end
    lcd_rw = 1;
    @(negedge clk);
    lcd_e = 0;
    for (int j = 0; j < S + 4; j++) begin
      @(posedge clk); #1;
      seen[1] = seen[1] | byte_valid;
    end
    lcd_rw = 0;
    chk("e_high_idle", seen, 8'h00);

    strobe(4'h4, 1, 0);
    do_reset();
    init4();
    send_byte(8'h48, 1);
    chk("post_reset_char", text[223:216], 8'h48);

    strobe(4'h4, 1, 1);
    strobe(4'h4, 1, 0);
    strobe(4'h7, 1, 1);
    strobe(4'h8, 1, 0);
    chk("rw_skip_byte", byte_out, 8'h48);

    send_byte(8'h04, 0);
    send_byte(8'h80, 0);
    send_byte(8'h41, 1);
    chk("entry_char", text[223:216], 8'h41);
`ifdef LCD_CAPTURE_ENTRY_MODE_EN
    chk("entry_addr", addr, 7'h7F);
`else
    chk("entry_addr", addr, 7'h01);
`endif
    send_byte(8'h06, 0);

    for (int i = 0; i < 80; i++) begin
      rs = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      if ($urandom_range(0, 9) == 0) strobe(4'($urandom), 1'($urandom), 1);
      if (!rs && $urandom_range(0, 3) == 0) b = {1'b1, 7'($urandom_range(0, 13) + (($urandom & 1) ? 64 : 0))};
      send_byte(b, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
